riscv_mem_subsys: RTL and testbench
===================================

// Module: riscv_mem_subsys
// PURPOSE
//  Parametrised unified memory subsystem for the RISC_V core: one single-ported word array serving an
//  instruction-fetch port and a data load/store port through valid/ready requests. Replaces the
//  zero-wait split instruction/data memories with configurable latency, byte strobes and 2-way arbitration.
//  Sits between CPU_wrapper (stall-capable) and the array; one transaction outstanding at a time.
// PARAMETERS
//  WIDTH      32    data/address width in bits (multiple of 8)
//  DEPTH      1024  array depth in words (power of 2, >=2)
//  LATENCY    2     cycles from request accept edge to resp_valid (>=1)
//  INIT_FILE  ""    hex image loaded with $readmemh at elaboration; "" = no load
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  i_req_valid  in   1          instruction fetch request
//  i_req_ready  out  1          fetch request accepted this cycle
//  i_addr       in   WIDTH      fetch byte address (PC)
//  i_resp_valid out  1          one-cycle pulse: i_rdata valid
//  i_rdata      out  WIDTH      fetched instruction word
//  d_req_valid  in   1          data request
//  d_req_ready  out  1          data request accepted this cycle
//  d_addr       in   WIDTH      data byte address
//  d_we         in   1          1 = store, 0 = load
//  d_be         in   WIDTH/8    store byte strobes (ignored on load)
//  d_wdata      in   WIDTH      store data
//  d_resp_valid out  1          one-cycle pulse: load data / store ack
//  d_rdata      out  WIDTH      load data (0 on store ack)
//  d_err        out  1          valid with d_resp_valid; misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FSM=IDLE, wait counter=0, last_grant=INSTR, all *_ready/*_resp_valid/d_err=0, rdata=0.
//    Array contents are not reset.
//  - Word index = addr[$clog2(WIDTH/8) +: $clog2(DEPTH)]; upper bits ignored (address wraps).
//  - FSM IDLE: if any req_valid, grant one port; its *_req_ready=1 combinationally in same cycle;
//    accept = valid&&ready. Both valid: round-robin, grant port != last_grant; last_grant updated on accept.
//  - Store writes array on the accept edge, per-byte d_be; load/fetch reads array on accept edge into a
//    holding register. No ready in any state except IDLE.
//  - IDLE -> WAIT (LATENCY>1, counter loads LATENCY-1, decrements) -> RESP; LATENCY==1: IDLE -> RESP.
//  - RESP: granted port's *_resp_valid=1 for exactly one cycle with holding data; next state IDLE.
//    Back-to-back throughput: one transaction per LATENCY+1 cycles.
//  - Requester must hold addr/wdata/be/we stable while valid && !ready; sampled only on accept.
//  - Store followed by load to same word returns new data (store committed before load can be accepted).
//  - Reset mid-transaction: FSM to IDLE, pending response dropped; a store already accepted stays written.
//  - Non-granted port's resp_valid/rdata never change while the other port is served.
// CONFIGURATION
//  Macro MEM_ALIGN_CHECK_EN:
//   defined: data access with d_addr[1:0]!=0 is accepted but not performed (no array write), completes
//            with d_resp_valid=1, d_err=1, d_rdata=0 after normal LATENCY; fetch with i_addr[1:0]!=0
//            returns 32'h0000_0013 (NOP) instead of array data.
//   undefined: low address bits ignored, d_err tied 0, no NOP substitution.
// STRUCTURE
//  - Package riscv_mem_pkg: state enum {IDLE,WAIT,RESP}, port-id enum {PORT_I,PORT_D},
//    localparam NOP_INSTR=32'h0000_0013, function byte_merge(old,new,be).
//  - Sub-module rr_arbiter2: 2-requester round-robin grant with last_grant register (enable = accept).
//  - Top holds array, FSM, wait counter, holding registers.
// TESTING
//  1 Reset: rst_n=0 -> all ready/resp_valid/d_err=0, rdata=0; release -> ready follows valid in IDLE.
//  2 Store d_addr=0x40,d_wdata=0xDEADBEEF,d_be=4'hF, then load 0x40 -> d_rdata=0xDEADBEEF exactly LATENCY
//    cycles after accept; d_be=4'b0010,d_wdata=0x0000AA00 -> reload gives 0xDEADAAEF.
//  3 Both ports valid continuously for 6 transactions -> grants alternate D,I,D,I,D,I; no port starved.
//  4 Address wrap: store to byte addr DEPTH*4+8 -> load from 0x8 returns stored word.
//  5 Reset asserted during WAIT of a store -> no resp_valid after reset; later load shows store committed.
//  6 With MEM_ALIGN_CHECK_EN: store to 0x41 -> d_err=1, array unchanged; fetch 0x2 -> i_rdata=0x00000013.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory subsystem.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // byte_merge works on the widest supported word; callers zero-extend and truncate.
  localparam int unsigned MAX_W  = 128;
  localparam int unsigned MAX_BE = MAX_W / 8;

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]  old_word,
                                                  input logic [MAX_W-1:0]  new_word,
                                                  input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < MAX_BE; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_mem_subsys_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant advances only on an accepted request.
module rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req_i,
  input  logic  req_d,
  input  logic  en,
  output port_t grant
);

  port_t last_grant;

  always_comb begin
    grant = PORT_I;
    if (req_i && req_d) begin
      grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      grant = PORT_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_I;
    end else if (en) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/riscv_mem_subsys.sv
// Unified single-ported memory serving fetch and load/store ports with fixed response latency.
// Optional MEM_ALIGN_CHECK_EN: misaligned data access -> d_err, misaligned fetch -> NOP.
module riscv_mem_subsys
  import riscv_mem_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_valid,
  output logic               i_req_ready,
  input  logic [WIDTH-1:0]   i_addr,
  output logic               i_resp_valid,
  output logic [WIDTH-1:0]   i_rdata,
  input  logic               d_req_valid,
  output logic               d_req_ready,
  input  logic [WIDTH-1:0]   d_addr,
  input  logic               d_we,
  input  logic [WIDTH/8-1:0] d_be,
  input  logic [WIDTH-1:0]   d_wdata,
  output logic               d_resp_valid,
  output logic [WIDTH-1:0]   d_rdata,
  output logic               d_err
);

  localparam int unsigned BE_W  = WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  port_t            grant, cur_port, acc_port_c, resp_port_c;
  logic [WIDTH-1:0] hold_data, acc_data_c, resp_data_c;
  logic             hold_err, acc_err_c, resp_err_c;
  logic [IDX_W-1:0] i_idx, d_idx;
  logic             i_misal, d_misal;
  logic             idle_c, i_acc, d_acc, acc;
  logic             unused_addr_bits;

  assign i_idx = i_addr[OFF_W +: IDX_W];
  assign d_idx = d_addr[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{i_addr, d_addr};

`ifdef MEM_ALIGN_CHECK_EN
  assign i_misal = (i_addr[1:0] != 2'b00);
  assign d_misal = (d_addr[1:0] != 2'b00);
`else
  assign i_misal = 1'b0;
  assign d_misal = 1'b0;
`endif

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (i_req_valid),
    .req_d (d_req_valid),
    .en    (acc),
    .grant (grant)
  );

  // Ready is only offered out of reset in IDLE, and only to the granted requester.
  assign idle_c      = rst_n && (state == IDLE);
  assign i_req_ready = idle_c && i_req_valid && (grant == PORT_I);
  assign d_req_ready = idle_c && d_req_valid && (grant == PORT_D);
  assign i_acc       = i_req_valid && i_req_ready;
  assign d_acc       = d_req_valid && d_req_ready;
  assign acc         = i_acc || d_acc;

  // Array write on the store accept edge; array itself has no reset.
  always_ff @(posedge clk) begin
    if (d_acc && d_we && !d_misal) begin
      mem[d_idx] <= WIDTH'(byte_merge(MAX_W'(mem[d_idx]), MAX_W'(d_wdata), MAX_BE'(d_be)));
    end
  end

  always_comb begin
    acc_port_c = PORT_I;
    acc_err_c  = 1'b0;
    acc_data_c = i_misal ? WIDTH'(NOP_INSTR) : mem[i_idx];
    if (d_acc) begin
      acc_port_c = PORT_D;
      acc_err_c  = d_misal;
      acc_data_c = (d_we || d_misal) ? '0 : mem[d_idx];
    end
  end

  // With LATENCY==1 the response is loaded straight from the accept path.
  always_comb begin
    resp_port_c = cur_port;
    resp_data_c = hold_data;
    resp_err_c  = hold_err;
    if (state == IDLE) begin
      resp_port_c = acc_port_c;
      resp_data_c = acc_data_c;
      resp_err_c  = acc_err_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_port  <= PORT_I;
      hold_data <= '0;
      hold_err  <= 1'b0;
    end else if (acc) begin
      cur_port  <= acc_port_c;
      hold_data <= acc_data_c;
      hold_err  <= acc_err_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (acc) begin
          if (LATENCY > 1) begin
            state_n = WAIT;
            cnt_n   = CNT_W'(LATENCY - 1);
          end else begin
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Response pulse registered on the edge that enters RESP; the idle port's outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_resp_valid <= 1'b0;
      i_rdata      <= '0;
      d_resp_valid <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      d_err        <= 1'b0;
      if (state_n == RESP) begin
        if (resp_port_c == PORT_D) begin
          d_resp_valid <= 1'b1;
          d_rdata      <= resp_data_c;
          d_err        <= resp_err_c;
        end else begin
          i_resp_valid <= 1'b1;
          i_rdata      <= resp_data_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_subsys.sv
// Scoreboard bench for riscv_mem_subsys: drivers queue expected responses, a monitor checks them.
module tb_riscv_mem_subsys;

  localparam int unsigned W   = 32;
  localparam int unsigned DEP = 1024;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid, i_req_ready, i_resp_valid;
  logic [W-1:0]  i_addr, i_rdata;
  logic          d_req_valid, d_req_ready, d_we, d_resp_valid, d_err;
  logic [W/8-1:0] d_be;
  logic [W-1:0]  d_addr, d_wdata, d_rdata;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t i_q[$];
  exp_t d_q[$];
  int   acc_log[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   d_pulses = 0;
  bit   log_en = 1'b0;

  riscv_mem_subsys #(.WIDTH(W), .DEPTH(DEP), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_addr       (i_addr),
    .i_resp_valid (i_resp_valid),
    .i_rdata      (i_rdata),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_addr       (d_addr),
    .d_we         (d_we),
    .d_be         (d_be),
    .d_wdata      (d_wdata),
    .d_resp_valid (d_resp_valid),
    .d_rdata      (d_rdata),
    .d_err        (d_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse pops its expectation and checks data, error and latency.
  always @(negedge clk) begin : mon
    exp_t e;
    if (log_en) begin
      if (d_req_valid && d_req_ready) acc_log.push_back(1);
      if (i_req_valid && i_req_ready) acc_log.push_back(0);
    end
    if (i_resp_valid) begin
      if (i_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL i_unexpected_resp act=%h exp=none", i_rdata);
      end else begin
        e = i_q.pop_front();
        chk("i_rdata", i_rdata, e.data);
        chk("i_latency", 32'(cyc - e.cyc), 32'(LAT));
      end
    end
    if (d_resp_valid) begin
      d_pulses++;
      if (d_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL d_unexpected_resp act=%h exp=none", d_rdata);
      end else begin
        e = d_q.pop_front();
        chk("d_rdata", d_rdata, e.data);
        chk("d_err", 32'(d_err), 32'(e.err));
        chk("d_latency", 32'(cyc - e.cyc), 32'(LAT));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic dreq(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
    d_req_valid = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (d_req_ready) begin
        d_q.push_back('{exp_d, exp_e, cyc});
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL d_accept_timeout act=no_ready exp=ready addr=%h", a);
    d_req_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d);
    i_req_valid = 1'b1; i_addr = a;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (i_req_ready) begin
        i_q.push_back('{exp_d, 1'b0, cyc});
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL i_accept_timeout act=no_ready exp=ready addr=%h", a);
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && (i_q.size() != 0 || d_q.size() != 0); n++) @(negedge clk);
    chk("drain_i", 32'(i_q.size()), 32'd0);
    chk("drain_d", 32'(d_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order[6] = '{1, 0, 1, 0, 1, 0};
    int p0;
    rst_n = 1'b0;
    i_req_valid = 1'b1; i_addr = '0;
    d_req_valid = 1'b1; d_addr = '0; d_we = 1'b0; d_be = '0; d_wdata = '0;

    // Reset state with both requests raised
    repeat (3) @(negedge clk);
    chk("rst_i_ready", 32'(i_req_ready), 32'd0);
    chk("rst_d_ready", 32'(d_req_ready), 32'd0);
    chk("rst_i_resp", 32'(i_resp_valid), 32'd0);
    chk("rst_d_resp", 32'(d_resp_valid), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 i_req_valid = 1'b1;
    @(negedge clk);
    chk("idle_i_ready", 32'(i_req_ready), 32'd1);
    chk("idle_d_ready_no_valid", 32'(d_req_ready), 32'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b1;
    #1;
    chk("idle_d_ready", 32'(d_req_ready), 32'd1);
    chk("idle_i_ready_no_valid", 32'(i_req_ready), 32'd0);
    d_req_valid = 1'b0;
    @(posedge clk); #1;

    // Store/load and partial byte strobe
    dreq(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    dreq(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    dreq(1'b1, 32'h40, 32'h0000AA00, 4'b0010, 32'h0, 1'b0);
    dreq(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);

    // Address wrap: DEPTH*4+8 aliases word 2
    dreq(1'b1, 32'(DEP * 4 + 8), 32'h12345678, 4'hF, 32'h0, 1'b0);
    dreq(1'b0, 32'h8, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // Preload instruction words; a lone fetch leaves last_grant on the fetch port
    dreq(1'b1, 32'h100, 32'h00A00093, 4'hF, 32'h0, 1'b0);
    dreq(1'b1, 32'h104, 32'h00108113, 4'hF, 32'h0, 1'b0);
    dreq(1'b1, 32'h108, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    fetch(32'h100, 32'h00A00093);
    drain();

    // Contention: both ports continuously valid
    log_en = 1'b1;
    fork
      begin
        dreq(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);
        dreq(1'b0, 32'h8, 32'h0, 4'h0, 32'h12345678, 1'b0);
        dreq(1'b0, 32'h108, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
      end
      begin
        fetch(32'h104, 32'h00108113);
        fetch(32'h108, 32'hCAFEF00D);
        fetch(32'h100, 32'h00A00093);
      end
    join
    drain();
    log_en = 1'b0;
    chk("rr_count", 32'(acc_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < acc_log.size()) chk($sformatf("rr_order_%0d", k), 32'(acc_log[k]), 32'(exp_order[k]));
    end

    // Reset while a store is in WAIT: response dropped, write kept
    dreq(1'b1, 32'h200, 32'h5A5A1234, 4'hF, 32'h0, 1'b0);
    rst_n = 1'b0;
    d_q.delete();
    p0 = d_pulses;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_drop_resp", 32'(d_pulses - p0), 32'd0);
    @(posedge clk); #1;
    dreq(1'b0, 32'h200, 32'h0, 4'h0, 32'h5A5A1234, 1'b0);
    drain();

`ifdef MEM_ALIGN_CHECK_EN
    dreq(1'b1, 32'h41, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    dreq(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);
    dreq(1'b0, 32'h42, 32'h0, 4'h0, 32'h0, 1'b1);
    fetch(32'h2, 32'h00000013);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
